if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue.
//
// Fetches sequential instruction words into a small FIFO. At most one memory
// request is outstanding at a time. A redirect flushes the queue and restarts
// fetching at the new PC. If the redirect arrives while a request is still
// outstanding, the late response is discarded (StFlush).
//
// Optional feature, enabled by defining ARVI_PREFETCH_BYPASS_EN:
//   When the queue is empty, a response can be presented at the head in the
//   same cycle it arrives. If it is also popped in that cycle, it is never
//   written into the FIFO.
//
// Parameters:
//   PC_RESET - address fetched first after reset
//   DEPTH    - FIFO entries, a power of two from 2 to 16
//
// Ports:
//   i_clk, i_rst     - clock (rising edge); asynchronous active-low reset
//   i_pop            - datapath consumed the head instruction
//   i_redirect(_pc)  - non-sequential PC change and its target
//   o_valid/o_instr  - head entry valid, and the head instruction
//   o_pc             - address of the head instruction
//   o_stall          - equals !o_valid
//   o_mem_req/_addr  - fetch request and its word-aligned address
//   i_mem_ready/data - response strobe (completes the request) and its data
module if_prefetch_queue #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pop,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]     f_addr_q, f_addr_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     flush_addr_q, flush_addr_d;
    logic [31:0]     fifo_q [DEPTH];

    logic        bypass;
    logic        fill;
    logic        take;
    logic [31:0] fetch_addr;

    assign fetch_addr = {f_addr_q[31:2], 2'b00};

    always_comb begin
        bypass = 1'b0;
`ifdef ARVI_PREFETCH_BYPASS_EN
        bypass = (state_q == StFetch) && (count_q == '0) && i_mem_ready && !i_redirect;
`endif
        // A bypassed word that is consumed at once never enters the FIFO.
        fill = (state_q == StFetch) && i_mem_ready && !i_redirect && !(bypass && i_pop);
        take = i_pop && (count_q != '0);
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        f_addr_d     = f_addr_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;

        if (i_redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            f_addr_d = i_redirect_pc;
            pc_d     = i_redirect_pc;
        end else begin
            if (fill) wr_ptr_d = wr_ptr_q + 1'b1;
            if (take) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CntW'(fill) - CntW'(take);
            if (take || (bypass && i_pop)) pc_d = pc_q + 32'd4;
            if ((state_q == StFetch) && i_mem_ready) f_addr_d = f_addr_q + 32'd4;
        end

        unique case (state_q)
            StIdle: begin
                if (count_q < CntFull) state_d = StFetch;
            end
            StFetch: begin
                if (i_redirect) begin
                    // Response still owed for the old address: wait it out.
                    if (!i_mem_ready) begin
                        state_d      = StFlush;
                        flush_addr_d = fetch_addr;
                    end
                end else if (i_mem_ready && (count_d == CntFull)) begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (i_mem_ready) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            f_addr_q     <= PC_RESET;
            pc_q         <= PC_RESET;
            flush_addr_q <= PC_RESET;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            f_addr_q     <= f_addr_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (fill) fifo_q[wr_ptr_q] <= i_mem_data;
    end

    always_comb begin
        o_valid = (count_q != '0) || bypass;
        o_stall = !o_valid;
        if (count_q != '0) begin
            o_instr = fifo_q[rd_ptr_q];
        end else if (bypass) begin
            o_instr = i_mem_data;
        end else begin
            o_instr = '0;
        end
        o_pc       = pc_q;
        o_mem_req  = (state_q != StIdle);
        o_mem_addr = (state_q == StFlush) ? flush_addr_q : fetch_addr;
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed vectors, a queue-based reference
// model compared every cycle, and literal expectations at the key points.
module tb_if_prefetch_queue;

    localparam logic [31:0] PcReset = 32'h0000_0100;
    localparam int unsigned Depth   = 4;
`ifdef ARVI_PREFETCH_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pop = 1'b0, redir = 1'b0, ready = 1'b0;
    logic [31:0] rpc = '0, mdata = '0;
    logic        valid, stall, mreq;
    logic [31:0] instr, pc, maddr;

    if_prefetch_queue #(.PC_RESET(PcReset), .DEPTH(Depth)) dut (
        .i_clk(clk), .i_rst(rst), .i_pop(pop), .i_redirect(redir),
        .i_redirect_pc(rpc), .o_valid(valid), .o_instr(instr), .o_pc(pc),
        .o_stall(stall), .o_mem_req(mreq), .o_mem_addr(maddr),
        .i_mem_ready(ready), .i_mem_data(mdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: queue of fetched words plus request bookkeeping.
    logic [31:0] q[$];
    logic [31:0] m_pc, m_faddr, m_dump_addr;
    bit          m_busy, m_dump;

    task automatic model_reset();
        q.delete();
        m_pc = PcReset; m_faddr = PcReset; m_dump_addr = PcReset;
        m_busy = 0; m_dump = 0;
    endtask

    // Compare DUT against model mid-cycle, then advance the model across the edge.
    task automatic cyc();
        int          sz;
        bit          byp, write;
        logic [31:0] e_instr, e_addr;
        @(negedge clk);
        sz    = q.size();
        write = m_busy && !m_dump && ready && !redir;
        byp   = Byp && write && (sz == 0);
        e_instr = (sz > 0) ? q[0] : (byp ? mdata : 32'h0);
        e_addr  = m_dump ? m_dump_addr : {m_faddr[31:2], 2'b00};
        check("valid", {31'b0, valid}, {31'b0, (sz > 0) || byp});
        check("stall", {31'b0, stall}, {31'b0, !((sz > 0) || byp)});
        check("mem_req", {31'b0, mreq}, {31'b0, m_busy});
        check("mem_addr", maddr, e_addr);
        check("pc", pc, m_pc);
        check("instr", instr, e_instr);
        if (redir) begin
            q.delete();
            if (!m_busy) m_busy = (sz < Depth);
            else if (m_dump) begin
                if (ready) m_dump = 0;
            end else if (!ready) begin
                m_dump = 1; m_dump_addr = {m_faddr[31:2], 2'b00};
            end
            m_pc = rpc; m_faddr = rpc;
        end else begin
            if (pop && sz > 0) begin
                void'(q.pop_front()); m_pc += 4;
            end
            if (byp && pop) m_pc += 4;
            else if (write) q.push_back(mdata);
            if (write) m_faddr += 4;
            if (!m_busy) m_busy = (sz < Depth);
            else if (m_dump) begin
                if (ready) m_dump = 0;
            end else if (ready) m_busy = (q.size() != Depth);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic r, input logic [31:0] t,
                         input logic rd, input logic [31:0] d);
        pop = p; redir = r; rpc = t; ready = rd; mdata = d;
    endtask

    logic [31:0] seen[$];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'b0, mreq}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd1);
        check("rst_pc", pc, 32'h100);
        check("rst_mem_addr", maddr, 32'h100);
        check("rst_instr", instr, 32'h0);
        rst = 1'b1;

        // Fill from reset with memory always ready.
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 32'hCAFE_0000 | {16'h0, m_faddr[15:0]});
            #2;
            if (mreq) seen.push_back(maddr);
            if (i == 0) check("first_req_cycle2", {31'b0, mreq}, 32'd0);
            cyc();
        end
        check("fill_req_count", seen.size(), 32'd4);
        if (seen.size() == 4) begin
            check("fill_addr0", seen[0], 32'h100);
            check("fill_addr1", seen[1], 32'h104);
            check("fill_addr2", seen[2], 32'h108);
            check("fill_addr3", seen[3], 32'h10C);
        end
        check("full_idle", {31'b0, mreq}, 32'd0);
        check("full_pc", pc, 32'h100);
        check("full_instr", instr, 32'hCAFE_0100);

        // Pop once from a full queue.
        drive(1, 0, 0, 0, 0); cyc();
        check("pop_pc", pc, 32'h104);
        drive(0, 0, 0, 0, 0); cyc();
        check("refill_req", {31'b0, mreq}, 32'd1);
        check("refill_addr", maddr, 32'h110);

        // Redirect to 0x100 while 0x110 pending, then fetch up to 0x108 pending.
        drive(0, 1, 32'h100, 0, 0); cyc();
        drive(0, 0, 0, 1, 32'h0BAD_0110); cyc();
        drive(0, 0, 0, 1, 32'hAAAA_0100); cyc();
        drive(0, 0, 0, 1, 32'hAAAA_0104); cyc();
        check("pend_addr_108", maddr, 32'h108);
        // Redirect to 0x200, response arrives three cycles later.
        drive(0, 1, 32'h200, 0, 0); cyc();
        check("flush_old_addr", maddr, 32'h108);
        check("flush_valid", {31'b0, valid}, 32'd0);
        drive(0, 0, 0, 0, 0); cyc();
        cyc();
        drive(0, 0, 0, 1, 32'hDEAD_BEEF); cyc();
        check("after_flush_addr", maddr, 32'h200);
        check("after_flush_valid", {31'b0, valid}, 32'd0);
        drive(0, 0, 0, 1, 32'h1111_1111); cyc();
        check("new_head_instr", instr, 32'h1111_1111);
        check("new_head_pc", pc, 32'h200);

        // Unaligned redirect coinciding with a response.
        drive(0, 1, 32'h302, 1, 32'h2222_2222); cyc();
        check("unal_addr", maddr, 32'h300);
        check("unal_pc", pc, 32'h302);
        check("unal_valid", {31'b0, valid}, 32'd0);

        // Empty queue: response 0x13 popped in the same cycle.
        drive(1, 0, 0, 1, 32'h0000_0013);
        #2;
        check("byp_same_valid", {31'b0, valid}, {31'b0, Byp});
        cyc();
        if (Byp) begin
            check("byp_next_valid", {31'b0, valid}, 32'd0);
            check("byp_next_pc", pc, 32'h306);
        end else begin
            check("nobyp_next_valid", {31'b0, valid}, 32'd1);
            check("nobyp_next_instr", instr, 32'h13);
            check("nobyp_next_pc", pc, 32'h302);
        end

        // Reset in the middle of a pending fetch; late ready during reset.
        drive(0, 0, 0, 0, 0); cyc();
        check("pre_rst_req", {31'b0, mreq}, 32'd1);
        #2;
        rst = 1'b0; ready = 1'b1; mdata = 32'hFFFF_0000;
        #1;
        check("arst_mem_req", {31'b0, mreq}, 32'd0);
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_stall", {31'b0, stall}, 32'd1);
        check("arst_pc", pc, 32'h100);
        check("arst_mem_addr", maddr, 32'h100);
        check("arst_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Mixed traffic to exercise pointer wrap and concurrent pop/write.
        for (int i = 0; i < 40; i++) begin
            drive((i % 3) == 0, i == 20, 32'h404, (i % 2) == 0, 32'h5000_0000 + i);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
